// File: rtl/conv_frame_ctrl_if.sv
// Handshake/bus bundle between the frame controller and its environment.
//   master : environment side (drives start, kernel words, pixels, conv results)
//   slave  : controller side (drives ready, windows, kernel, count, status)
interface conv_frame_ctrl_if #(
    parameter int unsigned DW = 12
);
    logic              i_start;
    logic [DW-1:0]     i_kernel_word;
    logic              i_kernel_word_valid;
    logic [DW-1:0]     i_pixel;
    logic              i_pixel_valid;
    logic              o_pixel_ready;
    logic [9*DW-1:0]   o_window;
    logic              o_window_valid;
    logic [9*DW-1:0]   o_kernel_vals;
    logic              o_kernel_reset;
    logic              i_conv_valid;
    logic [15:0]       o_out_count;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start, i_kernel_word, i_kernel_word_valid, i_pixel, i_pixel_valid, i_conv_valid,
        input  o_pixel_ready, o_window, o_window_valid, o_kernel_vals, o_kernel_reset,
               o_out_count, o_busy, o_done
    );

    modport slave (
        input  i_start, i_kernel_word, i_kernel_word_valid, i_pixel, i_pixel_valid, i_conv_valid,
        output o_pixel_ready, o_window, o_window_valid, o_kernel_vals, o_kernel_reset,
               o_out_count, o_busy, o_done
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 fixed-point convolution datapath.
// Loads a 9-word kernel serially and presents it packed with a one-cycle
// capture strobe, turns a raster pixel stream into 3x3 windows using two
// line buffers, then counts conv results and pulses done at frame end.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : start, kernel load, pixel stream, windows, kernel,
//                    conv result strobe, result count, busy/done status
module conv_frame_ctrl #(
    parameter int unsigned INTEGER_BITS     = 8,
    parameter int unsigned FIXED_POINT_BITS = 4,
    parameter int unsigned IMG_W            = 28,
    parameter int unsigned IMG_H            = 28
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    conv_frame_ctrl_if.slave   bus
);
    localparam int unsigned DW = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int unsigned KW = 9 * DW;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [15:0] N_RESULTS = 16'((IMG_W - 2) * (IMG_H - 2));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KLOAD  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      kidx;
    logic            kernel_loaded;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [KW-1:0]   window;
    logic [KW-1:0]   kernel_vals;
    logic            window_valid;
    logic            kernel_reset;
    logic            pixel_ready;
    logic            busy;
    logic            done;
    logic [15:0]     out_count;

    logic [DW-1:0]   kbuf [0:7];
    logic [DW-1:0]   lb0  [0:IMG_W-1];
    logic [DW-1:0]   lb1  [0:IMG_W-1];

    logic            accept_c;
    logic            start_take_c;
    logic            last_px_c;
    logic [15:0]     count_next_c;
    logic [KW-1:0]   kernel_pack_c;

    // pixel_ready is only ever set while streaming, so accept implies STREAM
    assign accept_c     = bus.i_pixel_valid & pixel_ready;
    assign start_take_c = (state == ST_IDLE) && bus.i_start && kernel_loaded;
    assign last_px_c    = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

    // Saturating result count; done compares against this so it fires the
    // cycle right after the final conv result.
    always_comb begin
        count_next_c = out_count;
        if (bus.i_conv_valid && (state == ST_STREAM || state == ST_FLUSH) &&
            out_count != 16'hFFFF) begin
            count_next_c = out_count + 16'd1;
        end
    end

    // Packed kernel with k0 in the MSBs; the final word comes straight from the bus
    always_comb begin
        kernel_pack_c = '0;
        for (int i = 0; i < 8; i++) begin
            kernel_pack_c[(8 - i) * DW +: DW] = kbuf[i];
        end
        kernel_pack_c[DW-1:0] = bus.i_kernel_word;
    end

    // Kernel staging and line buffers; not reset, window_valid gates stale data
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && bus.i_kernel_word_valid && !start_take_c) begin
            kbuf[0] <= bus.i_kernel_word;
        end
        if (state == ST_KLOAD && bus.i_kernel_word_valid && kidx < 4'd8) begin
            kbuf[kidx[2:0]] <= bus.i_kernel_word;
        end
        if (accept_c) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.i_pixel;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            kidx          <= 4'd0;
            kernel_loaded <= 1'b0;
            row           <= '0;
            col           <= '0;
            window        <= '0;
            window_valid  <= 1'b0;
            kernel_vals   <= '0;
            kernel_reset  <= 1'b0;
            pixel_ready   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            out_count     <= 16'd0;
        end else begin
            kernel_reset <= 1'b0;
            done         <= 1'b0;
            window_valid <= 1'b0;
            out_count    <= count_next_c;

            case (state)
                ST_IDLE: begin
                    if (start_take_c) begin
                        state       <= ST_STREAM;
                        row         <= '0;
                        col         <= '0;
                        out_count   <= 16'd0;
                        pixel_ready <= 1'b1;
                        busy        <= 1'b1;
                    end else if (bus.i_kernel_word_valid) begin
                        kernel_loaded <= 1'b0;
                        kidx          <= 4'd1;
                        state         <= ST_KLOAD;
                    end
                end

                ST_KLOAD: begin
                    if (bus.i_kernel_word_valid) begin
                        if (kidx == 4'd8) begin
                            kernel_vals   <= kernel_pack_c;
                            kernel_reset  <= 1'b1;
                            kernel_loaded <= 1'b1;
                            kidx          <= 4'd0;
                            state         <= ST_IDLE;
                        end else begin
                            kidx <= kidx + 4'd1;
                        end
                    end
                end

                ST_STREAM: begin
                    if (accept_c) begin
                        // Shift columns left; new column is {two rows up, one row up, pixel}
                        for (int r = 0; r < 3; r++) begin
                            window[(3 * r) * DW +: DW]     <= window[(3 * r + 1) * DW +: DW];
                            window[(3 * r + 1) * DW +: DW] <= window[(3 * r + 2) * DW +: DW];
                        end
                        window[2 * DW +: DW] <= lb1[col];
                        window[5 * DW +: DW] <= lb0[col];
                        window[8 * DW +: DW] <= bus.i_pixel;
                        // Windows straddling a row wrap (col < 2) are never valid
                        window_valid <= (row >= RW'(2)) && (col >= CW'(2));

                        if (col == CW'(IMG_W - 1)) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end

                        if (last_px_c) begin
                            state       <= ST_FLUSH;
                            pixel_ready <= 1'b0;
                        end
                    end
                end

                ST_FLUSH: begin
                    // No timeout: a missing conv result holds here until reset
                    if (count_next_c == N_RESULTS) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_pixel_ready  = pixel_ready;
    assign bus.o_window       = window;
    assign bus.o_window_valid = window_valid;
    assign bus.o_kernel_vals  = kernel_vals;
    assign bus.o_kernel_reset = kernel_reset;
    assign bus.o_out_count    = out_count;
    assign bus.o_busy         = busy;
    assign bus.o_done         = done;
endmodule
